// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath over a shared memory
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t cur, nxt;

    assign state = cur;

    // state register, aborts to FETCH the moment reset drops
    always_ff @(posedge clk or negedge reset)
        if (!reset) cur <= FETCH;
        else        cur <= nxt;

    // count fetches that actually completed
    always_ff @(posedge clk or negedge reset)
        if (!reset)                        retired <= '0;
        else if (cur == FETCH && mem_ready) retired <= retired + 32'd1;

    // next state and per-state controls; strobes are killed combinationally during reset
    always_comb begin
        nxt         = FETCH;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSrc       = 2'd0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        illegal     = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                nxt     = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCSrc       = 2'd1;
                PCWriteCond = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                nxt     = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = 2'd2;
                PCWrite = 1'b1;
            end
            default: nxt = FETCH;
        endcase
        if (!reset) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            illegal     = 1'b0;
        end
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1 bit: the shared memory has completed the current read or write this cycle.
REQ-005 SHALL have port IorD, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-006 SHALL have ports MemRead, MemWrite, IRWrite, output, 1 bit each: memory read strobe, memory write strobe, instruction register load.
REQ-007 SHALL have ports RegDst, MemToReg, RegWrite, output, 1 bit each: register file write-address select, writeback-data select, register file write enable.
REQ-008 SHALL have port ALUSrcA, output, 1 bit: ALU A input select (0 = PC, 1 = register A).
REQ-009 SHALL have port ALUSrcB, output, 2 bits: ALU B input select (0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left by 2).
REQ-010 SHALL have port ALUOp, output, 2 bits: 00 = add, 01 = subtract, 10 = funct-decoded; drives the existing ALU control.
REQ-011 SHALL have port PCSrc, output, 2 bits: next-PC select (0 = ALU result, 1 = ALUOut, 2 = jump target).
REQ-012 SHALL have ports PCWrite and PCWriteCond, output, 1 bit each: unconditional PC load, and PC load qualified by Zero.
REQ-013 SHALL have port state, output, 4 bits: current state encoding, for debug.
REQ-014 SHALL have port illegal, output, 1 bit: one-cycle pulse indicating an unsupported opcode.
REQ-015 SHALL have port retired, output, 32 bits: count of completed instruction fetches.

Function
REQ-016 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL return to FETCH on the next cycle.
REQ-017 FETCH SHALL assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00 and PCSrc=0.
REQ-018 FETCH SHALL assert IRWrite and PCWrite only in the cycle mem_ready=1.
REQ-019 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-020 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, ALUOp=00, then branch on opcode as follows:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXEC
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with illegal=1 for exactly that DECODE cycle.
REQ-021 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=2, ALUOp=00, then go to MEMRD if opcode is lw, or MEMWR if opcode is sw.
REQ-022 MEMRD SHALL drive MemRead=1 and IorD=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-023 MEMWR SHALL drive MemWrite=1 and IorD=1, hold while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-024 MEMWB SHALL drive RegWrite=1, RegDst=0, MemToReg=1, then go to FETCH.
REQ-025 EXEC SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=10, then go to ALUWB.
REQ-026 ALUWB SHALL drive RegWrite=1, RegDst=1, MemToReg=0, then go to FETCH.
REQ-027 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSrc=1, PCWriteCond=1, then go to FETCH.
REQ-028 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=2, ALUOp=00, then go to ADDIWB.
REQ-029 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemToReg=0, then go to FETCH.
REQ-030 JUMP SHALL drive PCSrc=2 and PCWrite=1, then go to FETCH.
REQ-031 Any output not listed for a state SHALL be 0 in that state.
REQ-032 MemRead and MemWrite SHALL never be asserted in the same cycle.
REQ-033 RegWrite, PCWrite and PCWriteCond SHALL each be asserted for at most one cycle per instruction.
REQ-034 Instruction latency with mem_ready held at 1 SHALL be:
- lw: 5 cycles
- sw, R-type, addi: 4 cycles
- beq, j: 3 cycles
- illegal opcode: 2 cycles.
REQ-035 Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle to the instruction latency.
REQ-036 mem_ready SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.
REQ-037 retired SHALL increment by 1 on each FETCH cycle with mem_ready=1, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-038 While reset=0, state SHALL be FETCH (0), retired SHALL be 0, and every strobe (MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond, illegal) SHALL be forced to 0, independent of clk.
REQ-039 Reset asserted mid-instruction (including MEMWR with mem_ready=0) SHALL abort the instruction immediately with no further writes.
REQ-040 After reset deassertion, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-041 Bench: lw (100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 with MemToReg=1 only in the state-4 cycle; retired +1.
REQ-042 Bench: R-type, then beq, then j, mem_ready=1 -> state sequences 0,1,6,7 / 0,1,8 / 0,1,11; PCWriteCond=1 only in state 8; PCSrc=2 in state 11.
REQ-043 Bench: sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held for 4 cycles, then FETCH; total latency 7 cycles; RegWrite never asserted.
REQ-044 Bench: opcode 111111 -> illegal=1 for one cycle in DECODE, next state 0, no RegWrite, MemWrite or PC write.
REQ-045 Bench: reset=0 asserted mid-MEMRD, between clock edges -> state=0 and MemRead=0 without waiting for a clock edge; retired=0.
REQ-046 Bench: preload retired to 0xFFFFFFFF via a forced state, then complete one fetch -> retired=0x00000000.
